// File: rtl/candidate_matcher.sv
// Compares a stream of brute-force candidate words against a loaded target password.
// Stops on the first match and reports the matching word, or reports keyspace exhaustion.
//
// state  | meaning
// IDLE   | waiting for a full target and a start pulse
// SEARCH | accepting one candidate per cycle and comparing it
// FOUND  | match captured; outputs held until start or reset
// DONE   | last candidate consumed without a match; outputs held
module candidate_matcher #(
  parameter int WORD_LEN = 4,
  parameter int CNT_W    = 24
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  target_load,
  input  logic [7:0]            target_letter,
  input  logic                  start,
  input  logic                  cand_valid,
  input  logic [8*WORD_LEN-1:0] cand_word,
  input  logic                  cand_last,
  output logic                  cand_ready,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic                  bad_letter,
  output logic [8*WORD_LEN-1:0] match_word,
  output logic [CNT_W-1:0]      attempts
);

  typedef enum logic [1:0] {IDLE, SEARCH, FOUND, DONE} state_t;

  state_t                state, state_next;
  logic [8*WORD_LEN-1:0] target;
  logic [2:0]            load_idx;
  logic                  target_full;
  logic                  start_ok;
  logic                  load_ok;
  logic                  xfer;
  logic                  eq;
  logic                  letter_bad;

  assign cand_ready = (state == SEARCH);
  assign busy       = (state == SEARCH);
  assign start_ok   = start && target_full && (state != SEARCH);
  // A simultaneous accepted start takes precedence over a target load.
  assign load_ok    = target_load && (state != SEARCH) && !start_ok;
  assign xfer       = cand_valid && (state == SEARCH);
  assign eq         = (cand_word == target);

  always_comb begin
    letter_bad = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (cand_word[8*i +: 8] < 8'h61 || cand_word[8*i +: 8] > 8'h7A)
        letter_bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      target      <= '0;
      load_idx    <= '0;
      target_full <= 1'b0;
    end else if (load_ok) begin
      for (int i = 0; i < WORD_LEN; i++) begin
        if (load_idx == 3'(i))
          target[8*i +: 8] <= target_letter;
      end
      if (load_idx == 3'(WORD_LEN-1)) begin
        load_idx    <= '0;
        target_full <= 1'b1;
      end else begin
        load_idx <= load_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, FOUND, DONE: if (start_ok) state_next = SEARCH;
      SEARCH: begin
        if (xfer) begin
          if (eq)             state_next = FOUND;
          else if (cand_last) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      found      <= 1'b0;
      exhausted  <= 1'b0;
      bad_letter <= 1'b0;
      match_word <= '0;
      attempts   <= '0;
    end else if (start_ok) begin
      found      <= 1'b0;
      exhausted  <= 1'b0;
      bad_letter <= 1'b0;
      match_word <= '0;
      attempts   <= '0;
    end else if (xfer) begin
      if (attempts != '1)
        attempts <= attempts + 1'b1;
      if (letter_bad)
        bad_letter <= 1'b1;
      // A match on the final candidate still reports found, never exhausted.
      if (eq) begin
        match_word <= cand_word;
        found      <= 1'b1;
      end else if (cand_last) begin
        exhausted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_candidate_matcher.sv
// Directed bench for candidate_matcher: reset, match, exhaustion, match-on-last,
// bad letters with restart, and reset during a search.
module tb_candidate_matcher;

  logic        clock = 1'b0;
  logic        resetn;
  logic        target_load;
  logic [7:0]  target_letter;
  logic        start;
  logic        cand_valid;
  logic [31:0] cand_word;
  logic        cand_last;
  logic        cand_ready;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic        bad_letter;
  logic [31:0] match_word;
  logic [23:0] attempts;

  int vectors = 0;
  int miscompares = 0;

  candidate_matcher #(.WORD_LEN(4), .CNT_W(24)) dut (
    .clock(clock), .resetn(resetn), .target_load(target_load),
    .target_letter(target_letter), .start(start), .cand_valid(cand_valid),
    .cand_word(cand_word), .cand_last(cand_last), .cand_ready(cand_ready),
    .busy(busy), .found(found), .exhausted(exhausted), .bad_letter(bad_letter),
    .match_word(match_word), .attempts(attempts)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] l);
    target_load = 1'b1;
    target_letter = l;
    step();
    target_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    cand_valid = 1'b1;
    cand_word = w;
    cand_last = last;
    step();
    cand_valid = 1'b0;
    cand_last = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(cand_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_found"}, 64'(found), 64'd0);
    check({tag, "_exh"}, 64'(exhausted), 64'd0);
    check({tag, "_bad"}, 64'(bad_letter), 64'd0);
    check({tag, "_mw"}, 64'(match_word), 64'd0);
    check({tag, "_att"}, 64'(attempts), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    target_load = 1'b0;
    target_letter = 8'h00;
    start = 1'b0;
    cand_valid = 1'b0;
    cand_word = 32'h0;
    cand_last = 1'b0;

    // Reset with random inputs wiggling
    for (int i = 0; i < 4; i++) begin
      target_load = 1'($urandom);
      target_letter = 8'($urandom);
      start = 1'($urandom);
      cand_valid = 1'($urandom);
      cand_word = $urandom;
      cand_last = 1'($urandom);
      step();
      check("rst_ready", 64'(cand_ready), 64'd0);
    end
    check_all_zero("rst");
    target_load = 1'b0; start = 1'b0; cand_valid = 1'b0; cand_last = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // start with no target loaded
    pulse_start();
    check("nostart_busy", 64'(busy), 64'd0);

    // Match mid-stream: target "cabs" = 0x73626163
    load(8'h63); load(8'h61); load(8'h62); load(8'h73);
    pulse_start();
    check("m_busy", 64'(busy), 64'd1);
    check("m_ready", 64'(cand_ready), 64'd1);
    for (int i = 0; i < 4; i++) send(32'h61616161, 1'b0);
    check("m_att4", 64'(attempts), 64'd4);
    check("m_found0", 64'(found), 64'd0);
    send(32'h73626163, 1'b0);
    check("m_found", 64'(found), 64'd1);
    check("m_mw", 64'(match_word), 64'h73626163);
    check("m_att", 64'(attempts), 64'd5);
    check("m_ready0", 64'(cand_ready), 64'd0);
    check("m_bad", 64'(bad_letter), 64'd0);
    send(32'h61616161, 1'b0);
    check("m_hold_att", 64'(attempts), 64'd5);
    check("m_hold_mw", 64'(match_word), 64'h73626163);

    // Exhaustion: target "zzzz"
    for (int i = 0; i < 4; i++) load(8'h7A);
    pulse_start();
    check("x_clr_found", 64'(found), 64'd0);
    check("x_clr_mw", 64'(match_word), 64'd0);
    send(32'h61616161, 1'b0);
    send(32'h62626262, 1'b0);
    send(32'h63636363, 1'b1);
    check("x_exh", 64'(exhausted), 64'd1);
    check("x_found", 64'(found), 64'd0);
    check("x_att", 64'(attempts), 64'd3);
    check("x_busy", 64'(busy), 64'd0);

    // Match on last candidate: target "aaaa"
    for (int i = 0; i < 4; i++) load(8'h61);
    pulse_start();
    check("l_exh_clr", 64'(exhausted), 64'd0);
    send(32'h61616161, 1'b1);
    check("l_found", 64'(found), 64'd1);
    check("l_exh", 64'(exhausted), 64'd0);
    check("l_att", 64'(attempts), 64'd1);
    check("l_mw", 64'(match_word), 64'h61616161);

    // Bad letter, then restart from DONE
    pulse_start();
    send(32'h61616141, 1'b0);
    check("b_bad", 64'(bad_letter), 64'd1);
    check("b_busy", 64'(busy), 64'd1);
    check("b_found", 64'(found), 64'd0);
    check("b_att", 64'(attempts), 64'd1);
    send(32'h62626262, 1'b1);
    check("b_exh", 64'(exhausted), 64'd1);
    check("b_bad_sticky", 64'(bad_letter), 64'd1);
    check("b_att2", 64'(attempts), 64'd2);
    pulse_start();
    check("b_restart_bad", 64'(bad_letter), 64'd0);
    check("b_restart_att", 64'(attempts), 64'd0);
    check("b_restart_busy", 64'(busy), 64'd1);
    check("b_restart_exh", 64'(exhausted), 64'd0);

    // Loads during SEARCH are ignored: target stays "aaaa"
    load(8'h7A);
    send(32'h62626262, 1'b0);
    send(32'h62626262, 1'b0);
    check("r_att2", 64'(attempts), 64'd2);

    // Reset mid-search, asynchronously
    cand_valid = 1'b1;
    cand_word = 32'h61616161;
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("r_async");
    step();
    cand_valid = 1'b0;
    resetn = 1'b1;
    step();
    check("r_att_after", 64'(attempts), 64'd0);
    pulse_start();
    check("r_start_ign0", 64'(busy), 64'd0);
    load(8'h64); load(8'h63); load(8'h62);
    pulse_start();
    check("r_start_ign3", 64'(busy), 64'd0);
    load(8'h61);
    pulse_start();
    check("r_start_ok", 64'(busy), 64'd1);
    send(32'h61626364, 1'b0);
    check("r_found", 64'(found), 64'd1);
    check("r_mw", 64'(match_word), 64'h61626364);
    check("r_att", 64'(attempts), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/candidate_matcher.md
# candidate_matcher

Consumes the stream of candidate words produced by the brute-force letter counter chain and compares each word against a loaded target password. It stops on the first match and reports the matching word and the attempt count. If the keyspace runs out without a match, it reports exhaustion. It sits at the receiving end of the candidate bus, downstream of the chained ASCII counters, and drives the system-level found/done indicators.

## Interface
- WORD_LEN, 4, letters per candidate/target word (1..8)
- CNT_W, 24, width of attempt counter
- clock  in  1  module clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- target_load  in  1  pulse: shift target_letter into next target slot
- target_letter  in  8  ASCII target letter
- start  in  1  pulse: begin search with current target
- cand_valid  in  1  candidate word present
- cand_word  in  8*WORD_LEN  candidate; letter 0 in [7:0], letter i in [8i+7:8i]
- cand_last  in  1  qualifies cand_word as final candidate of keyspace
- cand_ready  out  1  matcher accepts candidate this cycle
- busy  out  1  search in progress
- found  out  1  match found (sticky until start/reset)
- exhausted  out  1  last candidate consumed with no match (sticky)
- bad_letter  out  1  an accepted candidate held a letter outside 'a'..'z' (sticky)
- match_word  out  8*WORD_LEN  matching candidate, 0 otherwise
- attempts  out  CNT_W  candidates accepted since start, matching one included

## Operation
- State machine states: IDLE, SEARCH, FOUND, DONE. Reset state is IDLE.
- Target loading:
  - Honoured in IDLE, FOUND and DONE; ignored in SEARCH.
  - A 3-bit load_idx selects the slot. Each target_load writes target_letter into slot load_idx, then increments load_idx, wrapping WORD_LEN-1 -> 0.
  - target_full sets when slot WORD_LEN-1 is written and stays set until reset.
  - Loads after target_full overwrite slots cyclically starting at slot 0.
- start:
  - Accepted only when target_full=1 and state is not SEARCH; otherwise ignored.
  - If start and target_load occur in the same cycle, start wins and the load is dropped.
  - Accepted start clears found, exhausted, bad_letter, match_word and attempts, and moves the FSM to SEARCH.
- Handshake:
  - cand_ready = (state==SEARCH).
  - A transfer happens on an edge where cand_valid && cand_ready. The producer holds cand_word/cand_last until the transfer.
- Per transfer:
  - attempts increments, saturating at 2^CNT_W-1.
  - eq = (cand_word == target).
  - If any letter is <0x61 or >0x7A, bad_letter sets. The comparison still proceeds.
  - If eq: match_word <= cand_word, found <= 1, go to FOUND. This applies even when cand_last=1; found has priority and exhausted stays 0.
  - Else if cand_last: exhausted <= 1, go to DONE.
  - Else stay in SEARCH.
- FOUND and DONE hold all outputs until the next accepted start or reset.
- busy = (state==SEARCH).
- Reset mid-operation:
  - All outputs, target slots, load_idx and target_full clear immediately.
  - Any in-flight candidate is dropped.
  - A new search requires a full target reload.

## Timing
- Reset values: cand_ready 0, busy 0, found 0, exhausted 0, bad_letter 0, match_word 0, attempts 0.
- Start to ready: start sampled at edge N; cand_ready and busy are high from N+1.
- Throughput: one candidate per cycle in SEARCH.
- Match latency: matching candidate transferred at edge N; found=1, match_word and attempts valid, and cand_ready=0 after N. No candidate after the match is accepted.
- Exhaustion: exhausted=1 and cand_ready=0 after the edge that transfers cand_last.
- All outputs are registered, except cand_ready and busy, which decode directly from the state register.

## Test plan
- Reset: assert resetn=0 with random inputs -> every output 0 and cand_ready stays 0. start with no target loaded -> ignored, busy stays 0.
- Match mid-stream: load 'c','a','b','s', pulse start, stream 0x61616161 four times, then 0x73626163 -> found=1, match_word=0x73626163, attempts=5, cand_ready=0 on the following cycle; a held sixth word is not accepted.
- Exhaustion: target "zzzz", stream three non-matching words, the third with cand_last=1 -> exhausted=1, found=0, attempts=3, busy=0.
- Match on last: target 0x61616161, single candidate 0x61616161 with cand_last=1 -> found=1, exhausted=0, attempts=1.
- Bad letter and restart: candidate 0x61616141 ('A' in letter 0) -> bad_letter=1, search continues. Reach DONE, then pulse start -> bad_letter=0, attempts=0, busy=1.
- Reset mid-search: drop resetn after 2 accepted candidates -> outputs 0 asynchronously. start after release -> ignored until four target_load pulses are given.
